// File: rtl/quesadilla_pkg.sv
// Shared fetch/decode definitions: machine width and the fetch-entry record.
package quesadilla_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer, registered head, flush on redirect.
module instr_queue import quesadilla_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = quesadilla_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q < CW'(DEPTH)) && rst_n;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_pc       = mem_q[rd_ptr_q].pc;
  assign out_instr    = mem_q[rd_ptr_q].instr;
  assign out_misalign = mem_q[rd_ptr_q].misalign;
  assign count        = count_q;

  // Power-of-two DEPTH lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) begin
        mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr, misalign: pc_misaligned(in_pc[1:0])};
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: queue-based reference model with per-cycle compare plus literal checks.
module tb_instr_queue;
  import quesadilla_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_pc = '0;
  logic [31:0]     in_instr = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_pc;
  logic [31:0]     out_instr;
  logic            out_misalign;
  logic [CW-1:0]   count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  fetch_entry_t mq[$];

  instr_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_misalign(out_misalign), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries, updated from the inputs seen at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic int  sz = mq.size();
      automatic bit  do_push = in_valid && (sz < DEPTH);
      automatic bit  do_pop  = out_ready && (sz > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: in_pc, instr: in_instr, misalign: (in_pc[1:0] != 2'b00)});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc.count", count, mq.size());
      check("cyc.out_valid", out_valid, mq.size() != 0);
      check("cyc.in_ready", in_ready, rst_n && (mq.size() < DEPTH));
      if (mq.size() != 0) begin
        check("cyc.out_pc", out_pc, mq[0].pc);
        check("cyc.out_instr", out_instr, mq[0].instr);
        check("cyc.out_misalign", out_misalign, mq[0].misalign);
      end else if (!rst_n) begin
        check("cyc.rst_head", {out_pc, out_instr}, 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; in_pc = pc; in_instr = ins;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    chk_en = 1'b1;
    tick(); tick();
    check("rst.count", count, 0);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_after", in_ready, 1);

    // Single push, no fall-through.
    in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h0050_0093;
    #1;
    check("push1.no_fallthrough", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("push1.out_valid", out_valid, 1);
    check("push1.out_pc", out_pc, 32'h0);
    check("push1.out_instr", out_instr, 32'h0050_0093);
    check("push1.count", count, 1);
    pop1();
    check("push1.drained", count, 0);

    // Fill, refuse, drain in order.
    for (int i = 0; i < 4; i++) push1(32'(i * 4), 32'hA000_0000 + 32'(i));
    check("full.count", count, 4);
    check("full.in_ready", in_ready, 0);
    push1(32'h10, 32'hDEAD_BEEF);
    check("full.ignored", count, 4);
    for (int i = 0; i < 4; i++) begin
      check("full.order_pc", out_pc, 32'(i * 4));
      check("full.order_instr", out_instr, 32'hA000_0000 + 32'(i));
      pop1();
    end
    check("full.empty", count, 0);
    pop1();
    check("empty.no_underflow", count, 0);

    // Streaming push+pop across several pointer wraps.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = 32'(i * 4); in_instr = 32'h1000 + 32'(i);
      tick();
      check("stream.count", count, 1);
      check("stream.pc", out_pc, 32'(i * 4));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream.drained", count, 0);

    // Flush with a simultaneous push.
    push1(32'h20, 32'h1); push1(32'h24, 32'h2); push1(32'h28, 32'h3);
    check("flush.pre_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h30; in_instr = 32'h4;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.count", count, 0);
    check("flush.out_valid", out_valid, 0);
    check("flush.in_ready", in_ready, 1);
    push1(32'h100, 32'h5);
    push1(32'h104, 32'h6);
    check("flush.first_pc", out_pc, 32'h100);
    pop1();
    check("flush.second_pc", out_pc, 32'h104);
    pop1();

    // Misalignment flag.
    push1(32'h6, 32'h7);
    push1(32'h8, 32'h8);
    check("mis.flag_set", out_misalign, 1);
    pop1();
    check("mis.flag_clear", out_misalign, 0);
    check("mis.pc", out_pc, 32'h8);
    pop1();

    // Asynchronous reset mid-stream.
    push1(32'h200, 32'h9); push1(32'h204, 32'hA);
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h208; in_instr = 32'hB;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 0);
    check("arst.count", count, 0);
    check("arst.in_ready", in_ready, 0);
    check("arst.out_pc", out_pc, 32'h0);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("arst.in_ready_after", in_ready, 1);
    push1(32'h300, 32'hC);
    check("arst.push_after", out_pc, 32'h300);
    pop1();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queued fetch entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the fetch side presents an entry.
REQ-006 SHALL have port in_ready, output, 1 bit: the queue accepts an entry this cycle.
REQ-007 SHALL have port in_pc, input, XLEN bits: the PC of the fetched word.
REQ-008 SHALL have port in_instr, input, XLEN bits: the word read from instruction memory.
REQ-009 SHALL have port flush, input, 1 bit: discard all queued and incoming entries (branch redirect).
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-011 SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-012 SHALL have ports out_pc and out_instr, outputs, XLEN bits each: the head entry.
REQ-013 SHALL have port out_misalign, output, 1 bit: the head PC had bits [1:0] nonzero at push.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of entries held.

Function
REQ-015 SHALL push an entry when in_valid and in_ready are both high at a rising edge, storing {in_pc, in_instr, in_pc[1:0]!=0}.
REQ-016 SHALL drive in_ready = (count < DEPTH) and rst_n; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-017 SHALL pop the head when out_valid and out_ready are both high at a rising edge.
REQ-018 SHALL drive out_valid = (count != 0), with no fall-through: a push into an empty queue shows out_valid high one cycle after the push edge.
REQ-019 SHALL drive out_pc, out_instr and out_misalign directly from the head storage entry, stable while out_valid is high and not popped.
REQ-020 SHALL, on a simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and advance both pointers.
REQ-021 SHALL, when full, refuse pushes (in_ready low) and still allow a pop; the slot frees for a push on the next cycle.
REQ-022 SHALL ignore out_ready when empty, with no pointer change and no count underflow.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL give flush priority: on a flush edge, count, read pointer and write pointer go to 0, and any simultaneous push or pop is discarded; out_valid is low the following cycle.
REQ-025 SHALL accept pushes again in the cycle after flush.
REQ-026 SHALL pass the in_instr value through unmodified; no decoding is done.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force count=0, the pointers to 0, out_valid=0, in_ready=0, and out_pc=out_instr=0 with out_misalign=0 (storage cleared).
REQ-028 SHALL, on reset assertion mid-transfer, drop all entries; after rst_n rises, in_ready becomes 1 in the first cycle.

Structure
REQ-029 SHALL take XLEN and the fetch-entry typedef {pc, instr, misalign} from the shared package quesadilla_pkg, which the decode stage also uses.
REQ-030 SHALL be a single module; storage is an internal register array of DEPTH entries, with no sub-module.

Verification
REQ-031 SHALL have a bench that resets, then pushes pc=0x0, instr=0x00500093 -> out_valid=1 one cycle later with out_pc=0x0 and out_instr=0x00500093, and count=1.
REQ-032 SHALL have a bench that pushes 4 entries (pc 0x0, 0x4, 0x8, 0xC) with out_ready=0 -> count=4, in_ready=0, and a 5th push ignored; popping returns the order 0x0, 0x4, 0x8, 0xC.
REQ-033 SHALL have a bench that streams with in_valid=out_ready=1 for 20 cycles -> count constant at 1, outputs 0x0..0x4C in order, and pointers wrap without loss.
REQ-034 SHALL have a bench that asserts flush while count=3 with a simultaneous push -> count=0 and out_valid=0 the next cycle, and the next push pc=0x100 is the first popped.
REQ-035 SHALL have a bench that pushes pc=0x6 -> out_misalign=1 at the head; a following pc=0x8 -> out_misalign=0.
REQ-036 SHALL have a bench that drops rst_n mid-stream between clock edges -> out_valid=0 and count=0 immediately, with no clock edge required.
